// File: rtl/regfile_pkg.sv
// Shared definitions for the banked register file.
//   - clear-sequencer state encoding
//   - default geometry and the address widths derived from it
//   - width helper functions for non-default geometries
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int DW_DEF    = 4;
  localparam int NREG_DEF  = 16;
  localparam int NBANK_DEF = 2;

  localparam int ADDR4_W = $clog2(NREG_DEF);
  localparam int ADDR8_W = ADDR4_W - 1;
  localparam int BANK_W  = (NBANK_DEF > 1) ? $clog2(NBANK_DEF) : 1;

  function automatic int addr4_w(input int nreg);
    return $clog2(nreg);
  endfunction

  // A single bank still gets a one-bit select port, which is ignored.
  function automatic int bank_w(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer for the banked register file.
// Walks a pointer over every physical entry, one entry per cycle, then
// pulses done for a single cycle.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   clr_req_i   clear request, sampled only in IDLE
//   busy_o      clear in progress (user writes must be dropped)
//   clr_done_o  one-cycle pulse after the last entry is cleared
//   clr_we_o    write-zero strobe for entry clr_addr_o
//   clr_addr_o  physical entry currently being cleared
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for clr_req_i
// CLEAR | zeroing entry ptr_q, advancing one entry per cycle
// DONE  | single cycle, clr_done_o high, writes accepted again
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NENT = 32,
  localparam int PW = $clog2(NENT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          clr_done_o,
  output logic          clr_we_o,
  output logic [PW-1:0] clr_addr_o
);

  localparam logic [PW-1:0] LAST = PW'(NENT - 1);

  clr_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == CLEAR);
    clr_we_o   = (state_q == CLEAR);
    clr_done_o = (state_q == DONE);
    clr_addr_o = ptr_q;
  end

endmodule

// File: rtl/regfile_banked.sv
// Banked index register file: NBANK banks of NREG registers, DW bits each.
// One single-register port and one register-pair port, each with a write
// path and a one-cycle registered read path, plus a sequenced bulk clear.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   bank_sel_i             bank for every access this cycle
//   we4_i/addr4_i/wdata4_i single-register write
//   rdata4_o               single-register read data (addr4_i, 1 cycle later)
//   we8_i/addr8_i/wdata8_i pair write, low half to the even register
//   rdata8_o               pair read data {odd, even}, 1 cycle later
//   clr_req_i              request to zero every register in every bank
//   busy_o                 clear in progress, user writes dropped
//   clr_done_o             one-cycle pulse when the clear completes
//
// Build option: REGFILE_BYPASS_EN forwards same-cycle accepted write data
// to the read outputs, per DW slice, pair write winning over single write.
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NBANK = NBANK_DEF,
  localparam int A4W  = addr4_w(NREG),
  localparam int A8W  = A4W - 1,
  localparam int BW   = bank_w(NBANK)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [BW-1:0]   bank_sel_i,
  input  logic            we4_i,
  input  logic [A4W-1:0]  addr4_i,
  input  logic [DW-1:0]   wdata4_i,
  output logic [DW-1:0]   rdata4_o,
  input  logic            we8_i,
  input  logic [A8W-1:0]  addr8_i,
  input  logic [2*DW-1:0] wdata8_i,
  output logic [2*DW-1:0] rdata8_o,
  input  logic            clr_req_i,
  output logic            busy_o,
  output logic            clr_done_o
);

  localparam int NENT  = NBANK * NREG;
  localparam int IDX_W = $clog2(NENT);

  logic [DW-1:0]    mem_q [NENT];
  logic [DW-1:0]    rdata4_q, rdata4_d;
  logic [2*DW-1:0]  rdata8_q, rdata8_d;
  logic [IDX_W-1:0] idx4, idx8_e, idx8_o;
  logic [IDX_W-1:0] clr_addr;
  logic             clr_we, busy;
  logic             acc4, acc8;

  regfile_clear_seq #(
    .NENT (NENT)
  ) u_clr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_req_i  (clr_req_i),
    .busy_o     (busy),
    .clr_done_o (clr_done_o),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // With a power-of-two bank count the select is exactly log2 wide, so the
  // modulo wrap is implicit; a single bank ignores the select entirely.
  if (NBANK > 1) begin : g_banked
    assign idx4   = {bank_sel_i, addr4_i};
    assign idx8_e = {bank_sel_i, addr8_i, 1'b0};
    assign idx8_o = {bank_sel_i, addr8_i, 1'b1};
  end else begin : g_single
    assign idx4   = addr4_i;
    assign idx8_e = {addr8_i, 1'b0};
    assign idx8_o = {addr8_i, 1'b1};
  end

  assign acc4 = we4_i & ~busy;
  assign acc8 = we8_i & ~busy;

  // Pair write is applied after the single write so it wins on overlap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (acc4) mem_q[idx4] <= wdata4_i;
      if (acc8) begin
        mem_q[idx8_e] <= wdata8_i[DW-1:0];
        mem_q[idx8_o] <= wdata8_i[2*DW-1:DW];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Only accepted user writes are forwarded; clear writes and writes
  // dropped while busy are not.
  function automatic logic [DW-1:0] fwd_slice(input logic [IDX_W-1:0] idx,
                                              input logic [DW-1:0]    cur);
    logic [DW-1:0] res;
    res = cur;
    if (acc4 && (idx4 == idx))   res = wdata4_i;
    if (acc8 && (idx8_e == idx)) res = wdata8_i[DW-1:0];
    if (acc8 && (idx8_o == idx)) res = wdata8_i[2*DW-1:DW];
    return res;
  endfunction
`endif

  always_comb begin
    rdata4_d = mem_q[idx4];
    rdata8_d = {mem_q[idx8_o], mem_q[idx8_e]};
`ifdef REGFILE_BYPASS_EN
    rdata4_d = fwd_slice(idx4, rdata4_d);
    rdata8_d = {fwd_slice(idx8_o, rdata8_d[2*DW-1:DW]),
                fwd_slice(idx8_e, rdata8_d[DW-1:0])};
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata4_q <= '0;
      rdata8_q <= '0;
    end else begin
      rdata4_q <= rdata4_d;
      rdata8_q <= rdata8_d;
    end
  end

  assign rdata4_o = rdata4_q;
  assign rdata8_o = rdata8_q;
  assign busy_o   = busy;

endmodule

// File: tb/tb_regfile_banked.sv
module tb_regfile_banked;
  import regfile_pkg::*;

  localparam int NENT = NBANK_DEF * NREG_DEF;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b1;
  logic [BANK_W-1:0]     bank_sel_i;
  logic                  we4_i;
  logic [ADDR4_W-1:0]    addr4_i;
  logic [DW_DEF-1:0]     wdata4_i;
  logic [DW_DEF-1:0]     rdata4_o;
  logic                  we8_i;
  logic [ADDR8_W-1:0]    addr8_i;
  logic [2*DW_DEF-1:0]   wdata8_i;
  logic [2*DW_DEF-1:0]   rdata8_o;
  logic                  clr_req_i;
  logic                  busy_o;
  logic                  clr_done_o;

  always #5 clk_i = ~clk_i;

  regfile_banked #(
    .DW    (DW_DEF),
    .NREG  (NREG_DEF),
    .NBANK (NBANK_DEF)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bank_sel_i (bank_sel_i),
    .we4_i      (we4_i),
    .addr4_i    (addr4_i),
    .wdata4_i   (wdata4_i),
    .rdata4_o   (rdata4_o),
    .we8_i      (we8_i),
    .addr8_i    (addr8_i),
    .wdata8_i   (wdata8_i),
    .rdata8_o   (rdata8_o),
    .clr_req_i  (clr_req_i),
    .busy_o     (busy_o),
    .clr_done_o (clr_done_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [3:0] e4;
    logic [7:0] e8;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string      name;
    logic       b;
    logic       w4;
    logic [3:0] a4;
    logic [3:0] d4;
    logic       w8;
    logic [2:0] a8;
    logic [7:0] d8;
    logic [3:0] e4;
    logic [7:0] e8;
  } vec_t;
  vec_t vecs[18];

  logic [3:0] m [NENT];

  function automatic vec_t mk(input string n, input logic b, input logic w4,
                              input logic [3:0] a4, input logic [3:0] d4,
                              input logic w8, input logic [2:0] a8,
                              input logic [7:0] d8, input logic [3:0] e4,
                              input logic [7:0] e8);
    vec_t v;
    v.name = n; v.b = b; v.w4 = w4; v.a4 = a4; v.d4 = d4;
    v.w8 = w8; v.a8 = a8; v.d8 = d8; v.e4 = e4; v.e8 = e8;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick_chk(input string name, input logic [3:0] e4, input logic [7:0] e8);
    sb_t s;
    s.name = name; s.e4 = e4; s.e8 = e8;
    sbq.push_back(s);
    tick();
    s = sbq.pop_front();
    chk({s.name, "/rd4"}, 32'(rdata4_o), 32'(s.e4));
    chk({s.name, "/rd8"}, 32'(rdata8_o), 32'(s.e8));
  endtask

  task automatic idle_in();
    we4_i = 1'b0; we8_i = 1'b0; clr_req_i = 1'b0;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < NENT; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      bank_sel_i = iv[4];
      addr4_i    = iv[3:0];
      addr8_i    = iv[3:1];
      tick_chk($sformatf("%s_%0d", tag, i), m[i], {m[i | 1], m[i & ~1]});
    end
  endtask

  task automatic fill(input int seed);
    for (int p = 0; p < NENT / 2; p++) begin
      logic [3:0] pv, lo, hi;
      pv = 4'(p);
      lo = 4'((2 * p + seed) % 15 + 1);
      hi = 4'((2 * p + 1 + seed) % 15 + 1);
      bank_sel_i = pv[3];
      addr8_i    = pv[2:0];
      wdata8_i   = {hi, lo};
      we8_i      = 1'b1;
      m[2 * p]     = lo;
      m[2 * p + 1] = hi;
      tick();
    end
    we8_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation timeout");
  end

  initial begin
    int  cnt;
    bit  done_seen, busy_seen;

    vecs[0]  = mk("pr_wr",    0, 0, 6,  0, 1, 3, 8'hA5, BYP ? 4'h5 : 4'h0, BYP ? 8'hA5 : 8'h00);
    vecs[1]  = mk("pr_rd6",   0, 0, 6,  0, 0, 3, 8'h00, 4'h5, 8'hA5);
    vecs[2]  = mk("pr_rd7",   0, 0, 7,  0, 0, 3, 8'h00, 4'hA, 8'hA5);
    vecs[3]  = mk("b1_rd6",   1, 0, 6,  0, 0, 3, 8'h00, 4'h0, 8'h00);
    vecs[4]  = mk("b1_rd7",   1, 0, 7,  0, 0, 3, 8'h00, 4'h0, 8'h00);
    vecs[5]  = mk("coll_wr",  0, 1, 6,  1, 1, 3, 8'h3C, BYP ? 4'hC : 4'h5, BYP ? 8'h3C : 8'hA5);
    vecs[6]  = mk("coll_rd6", 0, 0, 6,  0, 0, 3, 8'h00, 4'hC, 8'h3C);
    vecs[7]  = mk("coll_rd7", 0, 0, 7,  0, 0, 3, 8'h00, 4'h3, 8'h3C);
    vecs[8]  = mk("r2_wr",    0, 1, 2,  9, 0, 1, 8'h00, BYP ? 4'h9 : 4'h0, BYP ? 8'h09 : 8'h00);
    vecs[9]  = mk("r2_rd",    0, 0, 2,  0, 0, 1, 8'h00, 4'h9, 8'h09);
    vecs[10] = mk("b1_pr_wr", 1, 0, 2,  0, 1, 1, 8'h7E, BYP ? 4'hE : 4'h0, BYP ? 8'h7E : 8'h00);
    vecs[11] = mk("b1_rd3",   1, 0, 3,  0, 0, 1, 8'h00, 4'h7, 8'h7E);
    vecs[12] = mk("b0_rd3",   0, 0, 3,  0, 0, 1, 8'h00, 4'h0, 8'h09);
    vecs[13] = mk("odd_coll", 1, 1, 15, 4'hD, 1, 7, 8'h42, BYP ? 4'h4 : 4'h0, BYP ? 8'h42 : 8'h00);
    vecs[14] = mk("odd_rd15", 1, 0, 15, 0, 0, 7, 8'h00, 4'h4, 8'h42);
    vecs[15] = mk("odd_rd14", 1, 0, 14, 0, 0, 7, 8'h00, 4'h2, 8'h42);
    vecs[16] = mk("split_wr", 0, 1, 0,  6, 1, 5, 8'h81, BYP ? 4'h6 : 4'h0, BYP ? 8'h81 : 8'h00);
    vecs[17] = mk("split_rd", 0, 0, 0,  0, 0, 5, 8'h00, 4'h6, 8'h81);

    idle_in();
    bank_sel_i = '0; addr4_i = '0; addr8_i = '0; wdata4_i = '0; wdata8_i = '0;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_rd4", 32'(rdata4_o), 0);
    chk("rst_rd8", 32'(rdata8_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(clr_done_o), 0);
    #2 rst_ni = 1'b1;
    tick();

    for (int i = 0; i < NENT; i++) m[i] = 4'h0;
    readback("rst_rd");

    for (int k = 0; k < 18; k++) begin
      bank_sel_i = vecs[k].b;
      we4_i      = vecs[k].w4;
      addr4_i    = vecs[k].a4;
      wdata4_i   = vecs[k].d4;
      we8_i      = vecs[k].w8;
      addr8_i    = vecs[k].a8;
      wdata8_i   = vecs[k].d8;
      tick_chk(vecs[k].name, vecs[k].e4, vecs[k].e8);
    end
    idle_in();

    fill(0);
    readback("fill_rd");

    // Clear with writes and a stray request hammering throughout.
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    chk("clr_busy_start", 32'(busy_o), 1);
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 100) begin
      cnt++;
      {bank_sel_i, addr4_i} = 5'(cnt);
      addr8_i   = addr4_i[3:1];
      we4_i     = 1'b1;
      wdata4_i  = 4'hF;
      we8_i     = 1'b1;
      wdata8_i  = 8'hFF;
      clr_req_i = (cnt == 7);
      tick();
      if (busy_o === 1'b1) chk("clr_no_early_done", 32'(clr_done_o), 0);
    end
    idle_in();
    chk("clr_busy_cycles", 32'(cnt), 32);
    chk("clr_done_pulse", 32'(clr_done_o), 1);
    chk("clr_busy_low_in_done", 32'(busy_o), 0);

    // DONE cycle: write is accepted, request is ignored.
    bank_sel_i = 1'b1; addr4_i = 4'd9; we4_i = 1'b1; wdata4_i = 4'hB; clr_req_i = 1'b1;
    tick();
    idle_in();
    chk("done_one_cycle", 32'(clr_done_o), 0);
    chk("done_req_ignored", 32'(busy_o), 0);
    for (int i = 0; i < NENT; i++) m[i] = 4'h0;
    m[25] = 4'hB;
    readback("clr_rd");

    // Reset in the middle of a clear.
    fill(5);
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    repeat (10) tick();
    chk("mid_busy", 32'(busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_done", 32'(clr_done_o), 0);
    chk("abort_rd4", 32'(rdata4_o), 0);
    chk("abort_rd8", 32'(rdata8_o), 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (clr_done_o === 1'b1) done_seen = 1'b1;
      if (busy_o !== 1'b0) busy_seen = 1'b1;
    end
    chk("abort_no_done_pulse", 32'(done_seen), 0);
    chk("abort_stays_idle", 32'(busy_seen), 0);
    for (int i = 0; i < NENT; i++) m[i] = 4'h0;
    readback("abort_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
- Parametrised successor to the 4004 index register file: NBANK banks of NREG registers, each DW bits wide.
- Provides one single-register (DW) port and one register-pair (2*DW) port; both have a write path and a synchronous read path.
- Adds a bank select, a sequenced bulk-clear engine with a busy/done handshake, and optional write-to-read forwarding.
- Sits between the CPU decoder/ALU datapath and the accumulator, as in the 4040-style core.

Parameters:
- DW, 4, register width in bits
- NREG, 16, registers per bank; must be even and a power of two
- NBANK, 2, number of banks; power of two, at least 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- bank_sel  in  max(1,log2 NBANK)  bank used by every access this cycle
- we4  in  1  single-register write enable
- addr4  in  log2 NREG  single-register index
- wdata4  in  DW  single-register write data
- rdata4  out  DW  single-register read data
- we8  in  1  pair write enable
- addr8  in  log2 NREG-1  pair index
- wdata8  in  2*DW  pair write data; low half goes to the even register
- rdata8  out  2*DW  pair read data, {odd, even}
- clr_req  in  1  one-cycle request to clear all registers in all banks
- busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (rst low, asynchronous): all NBANK*NREG registers are 0; rdata4=0, rdata8=0, busy=0, clr_done=0; the clear FSM returns to IDLE.
- Reset asserted mid-clear aborts the clear. No clr_done pulse is generated.

Addressing:
- Physical index = {bank_sel, addr4} for the single port.
- Pair port: even register = {bank_sel, addr8, 0}, odd register = {bank_sel, addr8, 1}.
- bank_sel values at or above NBANK wrap modulo NBANK.

Writes:
- Take effect on the rising edge when the enable is high and busy=0.
- we4 and we8 may both be active in the same cycle.
- If they target the same register, the we8 data wins for that register. The other register of the pair still takes wdata8.

Reads:
- Latency 1 cycle: rdata4/rdata8 register the array contents addressed in cycle N, visible in cycle N+1.
- Without forwarding, a same-cycle write is not visible; the read returns the pre-write value.
- Reads continue normally during a clear. Entries already cleared read as 0.

Clear FSM, states IDLE, CLEAR, DONE:
- IDLE: clr_req=1 -> CLEAR with ptr=0 and busy=1.
- CLEAR: each cycle writes 0 to register ptr and increments ptr.
  - When ptr = NBANK*NREG-1 is written -> DONE.
  - we4/we8 are ignored (dropped, not queued).
  - clr_req is ignored.
- DONE: one cycle; clr_done=1, busy=0 -> IDLE.
  - Writes are accepted in the DONE cycle.
  - clr_req in DONE is ignored.
- Total: busy is high for exactly NBANK*NREG cycles after the request edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if a write (single or pair, any winning data) targets a register being read in the same cycle, the read output in cycle N+1 returns the new write data, per DW slice. Forwarding follows the same we8-over-we4 priority.
- Undefined: old value returned, as in the 4004 block.
- Writes dropped because busy=1 are never forwarded.

Decomposition:
- Shared package regfile_pkg holds:
  - clear FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2)
  - localparam helpers for address widths (ADDR4_W, ADDR8_W, BANK_W)
- One sub-module, regfile_clear_seq, contains the FSM and ptr counter. It outputs busy, clr_done, clr_we and clr_addr.
- The storage array, write priority and read/bypass muxing stay in the top module.

Test Plan (defaults DW=4, NREG=16, NBANK=2):
- Reset then read all addresses in both banks -> every rdata4 = 4'h0 and every rdata8 = 8'h00, one cycle after each address.
- bank 0: we8 addr8=3 wdata8=8'hA5; next cycle read addr4=6 and addr4=7 -> 4'h5 and 4'hA. The same read with bank_sel=1 -> 4'h0.
- Same cycle: we4 addr4=6 data 4'h1 and we8 addr8=3 data 8'h3C -> reg6 = 4'hC, reg7 = 4'h3.
- Write reg2 = 4'h9 while reading addr4=2 in the same cycle -> rdata4 = old 4'h0 without REGFILE_BYPASS_EN, 4'h9 with it.
- Fill all 32 registers, pulse clr_req, and hold we4 high with data 4'hF throughout the clear:
  - busy is high for 32 cycles, then clr_done pulses for 1 cycle;
  - all registers read 0.
- Start a clear, assert rst low after 10 cycles -> busy=0 immediately, no clr_done pulse, all registers 0 after release.
